xadac_vrequant: RTL

XADAC_VREQUANT -- requirements
Module: xadac_vrequant

---
 rtl/xadac_vrequant.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/xadac_vrequant.sv
// xadac_vrequant: requantizes a vector of signed SumWidth-bit accumulators to
// signed ElemWidth-bit elements, one element per cycle, using a rounding
// arithmetic right shift followed by saturation. One transaction in flight.
module xadac_vrequant #(
    parameter int VecLen    = 8,
    parameter int SumWidth  = 32,
    parameter int ElemWidth = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [3:0]                    req_id,
    input  logic [$clog2(VecLen+1)-1:0]   req_vlen,
    input  logic [4:0]                    req_shift,
    input  logic [4:0]                    req_vd_addr,
    input  logic [VecLen*SumWidth-1:0]    req_vs_data,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [3:0]                    rsp_id,
    output logic [4:0]                    rsp_vd_addr,
    output logic [VecLen*ElemWidth-1:0]   rsp_vd_data,
    output logic                          rsp_vd_write,
    output logic                          rsp_sat
);
    localparam int LenW = $clog2(VecLen + 1);

    // Saturation bounds expressed in the widened (SumWidth+1) domain.
    localparam logic signed [SumWidth:0] ELEM_MAX =
        {{(SumWidth - ElemWidth + 2){1'b0}}, {(ElemWidth - 1){1'b1}}};
    localparam logic signed [SumWidth:0] ELEM_MIN =
        {{(SumWidth - ElemWidth + 2){1'b1}}, {(ElemWidth - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [3:0]                     id_r;
    logic [4:0]                     vd_addr_r;
    logic [4:0]                     shift_r;
    logic [VecLen*SumWidth-1:0]     vs_r;
    logic [LenW-1:0]                vlen_r;
    logic [LenW-1:0]                cnt_r;
    logic [VecLen*ElemWidth-1:0]    data_r;
    logic                           sat_r;

    logic [LenW-1:0]                vlen_clamp_s;
    logic                           last_s;
    logic signed [SumWidth-1:0]     x_s;
    logic signed [SumWidth:0]       xe_s;
    logic signed [SumWidth:0]       rnd_s;
    logic signed [SumWidth:0]       r_s;
    logic [ElemWidth:0]             q_s;

    // Clamp to the representable element range; MSB flags that clamping occurred.
    function automatic logic [ElemWidth:0] sat_elem(input logic signed [SumWidth:0] v);
        logic [ElemWidth:0] res;
        if (v > ELEM_MAX) begin
            res = {1'b1, ELEM_MAX[ElemWidth-1:0]};
        end else if (v < ELEM_MIN) begin
            res = {1'b1, ELEM_MIN[ElemWidth-1:0]};
        end else begin
            res = {1'b0, v[ElemWidth-1:0]};
        end
        return res;
    endfunction

    // Limit the requested element count to the vector length.
    always_comb begin
        vlen_clamp_s = req_vlen;
        if (req_vlen > LenW'(VecLen)) begin
            vlen_clamp_s = LenW'(VecLen);
        end else begin
            vlen_clamp_s = req_vlen;
        end
    end

    // Round-and-shift of the current element, widened by one bit so the
    // rounding addend can never overflow.
    always_comb begin
        x_s   = vs_r[cnt_r*SumWidth +: SumWidth];
        xe_s  = {x_s[SumWidth-1], x_s};
        rnd_s = '0;
        r_s   = xe_s;
        if (shift_r == 5'd0) begin
            r_s = xe_s;
        end else begin
            rnd_s = $signed({{SumWidth{1'b0}}, 1'b1} << (shift_r - 5'd1));
            r_s   = (xe_s + rnd_s) >>> shift_r;
        end
        q_s    = sat_elem(r_s);
        last_s = (cnt_r == (vlen_r - {{(LenW-1){1'b0}}, 1'b1}));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (vlen_clamp_s == '0) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Capture the request on acceptance and accumulate results while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_r      <= 4'd0;
            vd_addr_r <= 5'd0;
            shift_r   <= 5'd0;
            vs_r      <= '0;
            vlen_r    <= '0;
            cnt_r     <= '0;
            data_r    <= '0;
            sat_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        id_r      <= req_id;
                        vd_addr_r <= req_vd_addr;
                        shift_r   <= req_shift;
                        vs_r      <= req_vs_data;
                        vlen_r    <= vlen_clamp_s;
                        cnt_r     <= '0;
                        data_r    <= '0;
                        sat_r     <= 1'b0;
                    end
                end
                BUSY: begin
                    data_r[cnt_r*ElemWidth +: ElemWidth] <= q_s[ElemWidth-1:0];
                    sat_r <= sat_r | q_s[ElemWidth];
                    cnt_r <= cnt_r + {{(LenW-1){1'b0}}, 1'b1};
                end
                DONE: begin
                    sat_r <= sat_r;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign req_ready    = (state_r == IDLE);
    assign rsp_valid    = (state_r == DONE);
    assign rsp_vd_write = (state_r == DONE);
    assign rsp_id       = id_r;
    assign rsp_vd_addr  = vd_addr_r;
    assign rsp_vd_data  = data_r;
    assign rsp_sat      = sat_r;

endmodule
